// File: rtl/pocket_lab_spi_pkg.sv
// Shared SPI-slave definitions for the pocket_lab send/receive paths:
// byte width, bit-counter width, FSM state encoding and a shift helper.
package pocket_lab_spi_pkg;

  localparam int unsigned SPI_BYTE_W   = 8;
  localparam int unsigned SPI_BIT_CT_W = $clog2(SPI_BYTE_W);

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_SHIFT = 2'd1,
    STATE_FLUSH = 2'd2
  } spi_state_t;

  // Inserts one received bit; LSB-first shifts right so the first bit ends in bit 0.
  function automatic logic [SPI_BYTE_W-1:0] spi_shift_in(
    input logic [SPI_BYTE_W-1:0] cur,
    input logic                  bit_in,
    input logic                  msb_first
  );
    if (msb_first) spi_shift_in = {cur[SPI_BYTE_W-2:0], bit_in};
    else           spi_shift_in = {bit_in, cur[SPI_BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/spi_recv_fifo.sv
// Synchronous FIFO of {last,data} entries for the SPI receive path. Entry 0 is the
// registered head; pop shifts entries down. Full pushes are dropped and flagged sticky.
module spi_recv_fifo
  import pocket_lab_spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = SPI_BYTE_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic [CNT_W-1:0] count, count_n;
  logic             do_pop, do_push;

  assign do_pop  = pop & valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & ((count != CNT_FULL) | do_pop);
  assign head    = mem[0];

  always_comb begin
    mem_n   = mem;
    count_n = count;
    if (do_pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
      mem_n[DEPTH-1] = '0;
      count_n        = count - CNT_ONE;
    end
    if (do_push) begin
      mem_n[count_n[IDX_W-1:0]] = push_data;
      count_n                   = count_n + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      count    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      mem   <= mem_n;
      count <= count_n;
      valid <= (count_n != '0);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_recv.sv
// SPI-slave receive path: deserialises MOSI into bytes and streams them out as AXI4-Stream,
// flagging the last byte of each chip-select frame. Define SPI_RECV_MSB_FIRST_EN for MSB-first.
module spi_recv
  import pocket_lab_spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs,
  output logic [SPI_BYTE_W-1:0] axis_wdata,
  output logic                  axis_wvalid,
  input  logic                  axis_wready,
  output logic                  axis_wlast,
  output logic                  rx_overflow
);

`ifdef SPI_RECV_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic                   clk_s, cs_s, mosi_s, clk_d, cs_d;
  logic                   sample, cs_fall;

  spi_state_t               state;
  logic [SPI_BIT_CT_W-1:0]  bit_ct;
  logic [SPI_BYTE_W-1:0]    shift_reg, shift_next;
  logic [SPI_BYTE_W-1:0]    pend_data;
  logic                     pend_valid;
  logic                     push;
  logic [SPI_BYTE_W:0]      push_word;
  logic [SPI_BYTE_W:0]      head;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      clk_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      clk_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      clk_d     <= clk_s;
      cs_d      <= cs_s;
    end
  end

  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sample     = cs_s & clk_s & ~clk_d;
  assign cs_fall    = cs_d & ~cs_s;
  assign shift_next = spi_shift_in(shift_reg, mosi_s, MSB_FIRST);

  // A completed byte waits in pend_* until the next byte or frame end decides its last flag.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= STATE_IDLE;
      bit_ct     <= '0;
      shift_reg  <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      push       <= 1'b0;
      push_word  <= '0;
    end else begin
      push <= 1'b0;
      case (state)
        STATE_IDLE: begin
          bit_ct <= '0;
          if (cs_s) state <= STATE_SHIFT;
        end
        STATE_SHIFT: begin
          if (cs_fall) begin
            bit_ct <= '0;
            state  <= STATE_FLUSH;
          end else if (sample) begin
            shift_reg <= shift_next;
            bit_ct    <= bit_ct + SPI_BIT_CT_W'(1);
            if (bit_ct == '1) begin
              pend_data  <= shift_next;
              pend_valid <= 1'b1;
              if (pend_valid) begin
                push      <= 1'b1;
                push_word <= {1'b0, pend_data};
              end
            end
          end
        end
        STATE_FLUSH: begin
          if (pend_valid) begin
            push      <= 1'b1;
            push_word <= {1'b1, pend_data};
          end
          pend_valid <= 1'b0;
          state      <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  spi_recv_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SPI_BYTE_W + 1)
  ) u_fifo (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .push      (push),
    .push_data (push_word),
    .pop       (axis_wready),
    .head      (head),
    .valid     (axis_wvalid),
    .overflow  (rx_overflow)
  );

  assign axis_wdata = head[SPI_BYTE_W-1:0];
  assign axis_wlast = head[SPI_BYTE_W];

endmodule
